// File: rtl/reg_dump.sv
// Register-bank debug readout: walks [start_addr..end_addr] (wrapping) and streams each word.
// Latency: start -> first m_valid 2 cycles; one word per 2 cycles with m_ready held high.
// Backpressure: m_valid/m_data/m_last hold until m_ready; the walk stalls, nothing dropped.
//
// Ports: clk/rst (sync, active-high); start, start_addr, end_addr request a dump;
// ra/rd form the register-bank read port; m_valid/m_data/m_last/m_ready stream words out;
// busy is high outside IDLE; done pulses for one cycle after the final handshake.
// Optional macro REG_DUMP_CSUM_EN appends an XOR checksum word carrying m_last.
module reg_dump #(
    parameter int NREGS = 32,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] start_addr,
    input  logic [AW-1:0] end_addr,
    output logic [AW-1:0] ra,
    input  logic [DW-1:0] rd,
    output logic          busy,
    output logic          m_valid,
    output logic [DW-1:0] m_data,
    output logic          m_last,
    input  logic          m_ready,
    output logic          done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_CSUM,
        S_DONE
    } state_t;

    state_t        state;
    logic [AW-1:0] end_q;
    logic          last_q;
    logic [AW-1:0] ra_next;

`ifdef REG_DUMP_CSUM_EN
    logic [DW-1:0] acc;
`endif

    // ra doubles as the walk pointer; it only moves when entering LOAD,
    // so it holds the address of the word currently queued in SEND.
    assign ra_next = (ra == AW'(NREGS - 1)) ? '0 : ra + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            ra      <= '0;
            end_q   <= '0;
            last_q  <= 1'b0;
            busy    <= 1'b0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
            done    <= 1'b0;
`ifdef REG_DUMP_CSUM_EN
            acc     <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        ra    <= start_addr;
                        end_q <= end_addr;
                        busy  <= 1'b1;
                        state <= S_LOAD;
`ifdef REG_DUMP_CSUM_EN
                        acc   <= '0;
`endif
                    end
                end

                S_LOAD: begin
                    // Snapshot: later bank writes cannot alter the queued word.
                    m_data  <= rd;
                    last_q  <= (ra == end_q);
`ifdef REG_DUMP_CSUM_EN
                    m_last  <= 1'b0;
`else
                    m_last  <= (ra == end_q);
`endif
                    m_valid <= 1'b1;
                    state   <= S_SEND;
                end

                S_SEND: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
`ifdef REG_DUMP_CSUM_EN
                        acc     <= acc ^ m_data;
`endif
                        if (last_q) begin
`ifdef REG_DUMP_CSUM_EN
                            state <= S_CSUM;
`else
                            done  <= 1'b1;
                            state <= S_DONE;
`endif
                        end else begin
                            ra    <= ra_next;
                            state <= S_LOAD;
                        end
                    end
                end

`ifdef REG_DUMP_CSUM_EN
                S_CSUM: begin
                    // First cycle presents the checksum (accumulator now includes
                    // the last data word); remaining cycles wait for the handshake.
                    if (!m_valid) begin
                        m_valid <= 1'b1;
                        m_data  <= acc;
                        m_last  <= 1'b1;
                    end else if (m_ready) begin
                        m_valid <= 1'b0;
                        m_last  <= 1'b0;
                        done    <= 1'b1;
                        state   <= S_DONE;
                    end
                end
`endif

                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump.sv
module tb_reg_dump;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  start_addr = '0;
    logic [4:0]  end_addr = '0;
    logic [4:0]  ra;
    logic [31:0] rd;
    logic        busy;
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_last;
    logic        m_ready = 1'b0;
    logic        done;

    logic [31:0] bank [32];
    assign rd = bank[ra];

    reg_dump #(.NREGS(32), .AW(5), .DW(32)) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .end_addr(end_addr),
        .ra(ra), .rd(rd), .busy(busy), .m_valid(m_valid), .m_data(m_data),
        .m_last(m_last), .m_ready(m_ready), .done(done)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Captured handshakes from the most recent dump.
    logic [31:0] cap_data [$];
    bit          cap_last [$];
    logic [4:0]  cap_addr [$];
    int          cap_cyc  [$];
    int          done_cyc;
    int          stab_err;
    int          busy_err;
    bit          busy_after;
    bit          timed_out;

    // Reference expectation for a dump, from the range rules and a bank snapshot.
    logic [31:0] exp_data [$];
    bit          exp_last [$];
    logic [4:0]  exp_addr [$];

    function automatic void build_exp(input logic [4:0] s, input logic [4:0] e);
        int n;
        logic [31:0] x;
        n = ((int'(e) - int'(s) + 32) % 32) + 1;
        x = 32'h0;
        exp_data.delete(); exp_last.delete(); exp_addr.delete();
        for (int k = 0; k < n; k++) begin
            int a;
            a = (int'(s) + k) % 32;
            exp_data.push_back(bank[a]);
            exp_addr.push_back(5'(a));
            x = x ^ bank[a];
`ifdef REG_DUMP_CSUM_EN
            exp_last.push_back(1'b0);
`else
            exp_last.push_back(k == n - 1);
`endif
        end
`ifdef REG_DUMP_CSUM_EN
        exp_data.push_back(x);
        exp_last.push_back(1'b1);
        exp_addr.push_back(e);
`endif
    endfunction

    // Drives one dump and records every handshake. Cycle 1 is the cycle after
    // the edge that accepts start.
    task automatic do_dump(input logic [4:0] s, input logic [4:0] e, input int pct,
                           input int hold_addr, input int hold_n, input int haz_addr,
                           input int busy_start_cyc);
        int c, held;
        bit pv, hz_done, r;
        logic [31:0] pdata;
        bit plast;
        cap_data.delete(); cap_last.delete(); cap_addr.delete(); cap_cyc.delete();
        done_cyc = -1; stab_err = 0; busy_err = 0; timed_out = 0; busy_after = 1'b1;
        @(negedge clk);
        start = 1'b1; start_addr = s; end_addr = e;
        @(negedge clk);
        start = 1'b0;
        c = 1; held = 0; pv = 0; hz_done = 0; pdata = '0; plast = 0;
        while (c < 2000) begin
            if (pv && !(m_valid === 1'b1 && m_data === pdata && m_last === plast)) stab_err++;
            if (done === 1'b1) begin
                done_cyc = c;
                break;
            end
            if (busy !== 1'b1) busy_err++;
            if (haz_addr >= 0 && !hz_done && m_valid && int'(ra) == haz_addr) begin
                bank[haz_addr] = ~bank[haz_addr];
                hz_done = 1;
            end
            if (c == busy_start_cyc) begin
                start = 1'b1; start_addr = s + 5'd3; end_addr = s + 5'd1;
            end else begin
                start = 1'b0;
            end
            r = ($urandom_range(99) < pct);
            if (hold_addr >= 0 && m_valid && int'(ra) == hold_addr && held < hold_n) begin
                r = 0;
                held++;
            end
            m_ready = r;
            if (m_valid && m_ready) begin
                cap_data.push_back(m_data);
                cap_last.push_back(m_last);
                cap_addr.push_back(ra);
                cap_cyc.push_back(c);
            end
            pv = m_valid && !m_ready;
            pdata = m_data;
            plast = m_last;
            @(negedge clk);
            c++;
        end
        if (c >= 2000) timed_out = 1;
        m_ready = 1'b0;
        start = 1'b0;
        @(negedge clk);
        busy_after = busy;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({ra, busy, m_valid, m_data, m_last, done} !== '0) begin
                failures++;
                $display("FAIL reset_idle cyc%0d: ra=%0d busy=%b vld=%b data=%h last=%b done=%b, want all 0",
                         i, ra, busy, m_valid, m_data, m_last, done);
            end
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 32; i++) bank[i] = i * 32'h11111111;
        build_exp(5'd0, 5'd31);
        do_dump(5'd0, 5'd31, 100, -1, 0, -1, -1);
        checks++;
        if (timed_out || cap_data.size() != exp_data.size()) begin
            failures++;
            $display("FAIL full_count: got %0d words timeout=%b, want %0d", cap_data.size(), timed_out, exp_data.size());
        end else begin
            for (int k = 0; k < exp_data.size(); k++) begin
                checks++;
                if (cap_data[k] !== exp_data[k] || cap_last[k] !== exp_last[k] || cap_addr[k] !== exp_addr[k]) begin
                    failures++;
                    $display("FAIL full_word%0d: data=%h last=%b addr=%0d, want data=%h last=%b addr=%0d",
                             k, cap_data[k], cap_last[k], cap_addr[k], exp_data[k], exp_last[k], exp_addr[k]);
                end
                if (k > 0) begin
                    checks++;
                    if (cap_cyc[k] - cap_cyc[k-1] != 2) begin
                        failures++;
                        $display("FAIL full_spacing%0d: got %0d cycles, want 2", k, cap_cyc[k] - cap_cyc[k-1]);
                    end
                end
            end
            checks++;
            if (cap_cyc[0] != 2) begin
                failures++;
                $display("FAIL full_first_latency: got cycle %0d, want 2", cap_cyc[0]);
            end
            checks++;
            if (done_cyc != cap_cyc[cap_cyc.size()-1] + 1) begin
                failures++;
                $display("FAIL full_done_cycle: got %0d, want %0d", done_cyc, cap_cyc[cap_cyc.size()-1] + 1);
            end
        end
        checks++;
        if (busy_after !== 1'b0 || busy_err != 0) begin
            failures++;
            $display("FAIL full_busy: after_done=%b low_during=%0d, want 0 and 0", busy_after, busy_err);
        end
    endtask

    task automatic test_backpressure();
        build_exp(5'd4, 5'd6);
        do_dump(5'd4, 5'd6, 100, 5, 5, -1, -1);
        checks++;
        if (timed_out || cap_data.size() != exp_data.size()) begin
            failures++;
            $display("FAIL bp_count: got %0d words, want %0d", cap_data.size(), exp_data.size());
        end else begin
            for (int k = 0; k < exp_data.size(); k++) begin
                checks++;
                if (cap_data[k] !== exp_data[k] || cap_last[k] !== exp_last[k]) begin
                    failures++;
                    $display("FAIL bp_word%0d: data=%h last=%b, want %h %b", k, cap_data[k], cap_last[k], exp_data[k], exp_last[k]);
                end
            end
            checks++;
            if (cap_data[1] !== 32'h55555555 || cap_cyc[1] - cap_cyc[0] != 7) begin
                failures++;
                $display("FAIL bp_held_word: data=%h gap=%0d, want 55555555 gap 7", cap_data[1], cap_cyc[1] - cap_cyc[0]);
            end
        end
        checks++;
        if (stab_err != 0) begin
            failures++;
            $display("FAIL bp_stability: %0d unstable stall cycles, want 0", stab_err);
        end
    endtask

    task automatic test_wrap_single();
        build_exp(5'd30, 5'd1);
        do_dump(5'd30, 5'd1, 100, -1, 0, -1, -1);
        checks++;
        if (timed_out || cap_addr.size() != exp_addr.size()) begin
            failures++;
            $display("FAIL wrap_count: got %0d words, want %0d", cap_addr.size(), exp_addr.size());
        end else begin
            for (int k = 0; k < exp_addr.size(); k++) begin
                checks++;
                if (cap_addr[k] !== exp_addr[k] || cap_data[k] !== exp_data[k] || cap_last[k] !== exp_last[k]) begin
                    failures++;
                    $display("FAIL wrap_word%0d: addr=%0d data=%h last=%b, want %0d %h %b",
                             k, cap_addr[k], cap_data[k], cap_last[k], exp_addr[k], exp_data[k], exp_last[k]);
                end
            end
        end
        build_exp(5'd7, 5'd7);
        do_dump(5'd7, 5'd7, 100, -1, 0, -1, -1);
        checks++;
`ifdef REG_DUMP_CSUM_EN
        if (timed_out || cap_data.size() != 2 || cap_data[0] !== bank[7] || cap_last[0] !== 1'b0
            || cap_data[1] !== bank[7] || cap_last[1] !== 1'b1) begin
`else
        if (timed_out || cap_data.size() != 1 || cap_data[0] !== bank[7] || cap_last[0] !== 1'b1) begin
`endif
            failures++;
            $display("FAIL single_word: count=%0d first=%h last=%b, want reg7=%h",
                     cap_data.size(), (cap_data.size() > 0) ? cap_data[0] : 32'hx,
                     (cap_last.size() > 0) ? cap_last[0] : 1'bx, bank[7]);
        end
    endtask

    task automatic test_hazards();
        logic [31:0] old9;
        bit bad;
        old9 = bank[9];
        build_exp(5'd8, 5'd10);
        do_dump(5'd8, 5'd10, 100, -1, 0, 9, -1);
        checks++;
        if (timed_out || cap_data.size() < 2 || cap_data[1] !== old9 || bank[9] === old9) begin
            failures++;
            $display("FAIL snapshot_reg9: sent=%h, want old %h", (cap_data.size() > 1) ? cap_data[1] : 32'hx, old9);
        end
        // start pulse during busy must be ignored
        build_exp(5'd12, 5'd15);
        do_dump(5'd12, 5'd15, 100, -1, 0, -1, 3);
        checks++;
        bad = (timed_out || cap_data.size() != exp_data.size());
        if (!bad)
            for (int k = 0; k < exp_data.size(); k++)
                if (cap_data[k] !== exp_data[k] || cap_addr[k] !== exp_addr[k]) bad = 1;
        if (bad) begin
            failures++;
            $display("FAIL start_while_busy_seq: got %0d words, want %0d unchanged", cap_data.size(), exp_data.size());
        end
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (m_valid !== 1'b0 || busy !== 1'b0) bad = 1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL start_while_busy_idle: vld=%b busy=%b after dump, want 0 0", m_valid, busy);
        end
        // reset mid-dump
        @(negedge clk);
        start = 1'b1; start_addr = 5'd0; end_addr = 5'd31;
        @(negedge clk);
        start = 1'b0; m_ready = 1'b1;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || ra !== 5'd0) begin
            failures++;
            $display("FAIL rst_mid_dump: vld=%b busy=%b done=%b ra=%0d, want 0 0 0 0", m_valid, busy, done, ra);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || m_valid !== 1'b0) bad = 1;
        end
        m_ready = 1'b0;
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL rst_mid_no_done: saw done/valid after reset, want none");
        end
    endtask

    task automatic test_csum();
        bank[0] = 32'h1; bank[1] = 32'h2; bank[2] = 32'h4;
        do_dump(5'd0, 5'd2, 100, -1, 0, -1, -1);
        checks++;
`ifdef REG_DUMP_CSUM_EN
        if (timed_out || cap_data.size() != 4 || cap_data[2] !== 32'h4 || cap_last[2] !== 1'b0
            || cap_data[3] !== 32'h7 || cap_last[3] !== 1'b1) begin
`else
        if (timed_out || cap_data.size() != 3 || cap_data[0] !== 32'h1 || cap_data[1] !== 32'h2
            || cap_data[2] !== 32'h4 || cap_last[2] !== 1'b1 || cap_last[1] !== 1'b0) begin
`endif
            failures++;
            $display("FAIL csum_tail: count=%0d final=%h last=%b",
                     cap_data.size(), (cap_data.size() > 0) ? cap_data[cap_data.size()-1] : 32'hx,
                     (cap_last.size() > 0) ? cap_last[cap_last.size()-1] : 1'bx);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            logic [4:0] s, e;
            int pct;
            bit bad;
            for (int i = 0; i < 32; i++) bank[i] = $urandom;
            s = 5'($urandom_range(31));
            e = 5'($urandom_range(31));
            pct = $urandom_range(100, 30);
            build_exp(s, e);
            do_dump(s, e, pct, -1, 0, -1, -1);
            bad = (timed_out || cap_data.size() != exp_data.size());
            if (!bad)
                for (int k = 0; k < exp_data.size(); k++)
                    if (cap_data[k] !== exp_data[k] || cap_last[k] !== exp_last[k] || cap_addr[k] !== exp_addr[k])
                        bad = 1;
            checks++;
            if (bad || stab_err != 0 || busy_err != 0 || busy_after !== 1'b0) begin
                failures++;
                $display("FAIL random%0d s=%0d e=%0d: words=%0d want %0d stab=%0d busy_err=%0d busy_after=%b",
                         it, s, e, cap_data.size(), exp_data.size(), stab_err, busy_err, busy_after);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) bank[i] = '0;
        test_reset();
        test_full();
        test_backpressure();
        test_wrap_single();
        test_hazards();
        test_csum();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
